// File: rtl/onchipalarm_button_pio.sv
// Avalon-MM input PIO for push buttons and switches.
// Each input bit is synchronised, debounced and polarity-normalised (1 = pressed).
// Edges of the debounced level are captured in a W1C register that drives a
// maskable level interrupt.
module onchipalarm_button_pio #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter bit ACTIVE_LOW      = 1'b1,
    parameter int EDGE_TYPE       = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        REG_DATA = 2'd0,
        REG_RSVD = 2'd1,
        REG_MASK = 2'd2,
        REG_EDGE = 2'd3
    } reg_addr_t;

    logic [WIDTH-1:0] in_n;
    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] stable_d;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] ev;
    logic [WIDTH-1:0] clr;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] edge_cap;
    logic [CW-1:0]    cnt [WIDTH];
    logic             wr_en;
    logic [31:0]      rd_mux;
    logic             unused_wdata;

    assign in_n         = ACTIVE_LOW ? ~in_port : in_port;
    assign wr_en        = chipselect & ~write_n;
    assign unused_wdata = ^writedata;

    // Two-flop synchroniser on the normalised pin level
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= in_n;
            sync2 <= sync1;
        end
    end

    // Per-bit debouncer: a new level must persist DEBOUNCE_CYCLES cycles to be accepted
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable <= '0;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if (sync2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    stable[i] <= sync2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    // Edge selection and W1C clear decode
    always_comb begin
        rise = stable & ~stable_d;
        fall = ~stable & stable_d;
        case (EDGE_TYPE)
            0:       ev = rise;
            1:       ev = fall;
            default: ev = rise | fall;
        endcase
        clr = '0;
        if (wr_en && address == REG_EDGE) begin
            clr = writedata[WIDTH-1:0];
        end
    end

    // Edge capture and interrupt mask registers; a new event wins over a same-cycle clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable_d <= '0;
            mask     <= '0;
            edge_cap <= '0;
        end else begin
            stable_d <= stable;
            edge_cap <= (edge_cap & ~clr) | ev;
            if (wr_en && address == REG_MASK) begin
                mask <= writedata[WIDTH-1:0];
            end
        end
    end

    assign irq = |(edge_cap & mask);

    // Read mux; chipselect does not qualify reads
    always_comb begin
        rd_mux = '0;
        case (address)
            REG_DATA: rd_mux[WIDTH-1:0] = stable;
            REG_MASK: rd_mux[WIDTH-1:0] = mask;
            REG_EDGE: rd_mux[WIDTH-1:0] = edge_cap;
            default:  rd_mux = '0;
        endcase
    end

    // Registered read data, one cycle of latency
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            readdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_onchipalarm_button_pio.sv
// Bench for onchipalarm_button_pio: directed scenarios plus randomized traffic.
// A reference model pushes the expected readdata/irq for every clock into a
// scoreboard queue; a monitor pops and compares after each edge.
module tb_onchipalarm_button_pio;

    localparam int W  = 4;
    localparam int D  = 4;
    localparam int ET = 0;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [1:0]    address = 2'd0;
    logic          chipselect = 1'b0;
    logic          write_n = 1'b1;
    logic [31:0]   writedata = '0;
    logic [W-1:0]  in_port = '1;
    logic [31:0]   readdata;
    logic [31:0]   readdata_r;
    logic          irq;
    logic          irq_r;

    always #5 clk = ~clk;

    onchipalarm_button_pio #(
        .WIDTH(W), .DEBOUNCE_CYCLES(D), .ACTIVE_LOW(1'b1), .EDGE_TYPE(ET)
    ) u_dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .in_port(in_port), .irq(irq)
    );

    // Release-capturing variant sharing the same stimulus
    onchipalarm_button_pio #(
        .WIDTH(W), .DEBOUNCE_CYCLES(D), .ACTIVE_LOW(1'b1), .EDGE_TYPE(1)
    ) u_dut_rel (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata_r),
        .in_port(in_port), .irq(irq_r)
    );

    typedef struct {
        logic [31:0] rd;
        logic        irq;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: a bit's debounced level becomes v once the synchronised
    // samples seen over the last D cycles are all v and differ from the current level.
    logic [W-1:0] m_stable, m_stable_d, m_mask, m_edge;
    logic [W-1:0] hist[$];  // hist[0] = newest sync1 sample, hist[1] = current sync2

    always @(posedge clk) begin : model
        logic [W-1:0] nxt, ev, clr, rdv;
        logic         all_same, v;
        exp_t         e;
        if (!reset_n) begin
            m_stable = '0; m_stable_d = '0; m_mask = '0; m_edge = '0;
            hist = {};
            for (int j = 0; j <= D; j++) hist.push_back('0);
            e.rd = '0;
            e.irq = 1'b0;
        end else begin
            nxt = m_stable;
            for (int b = 0; b < W; b++) begin
                v = hist[1][b];
                all_same = 1'b1;
                for (int j = 2; j <= D; j++) if (hist[j][b] != v) all_same = 1'b0;
                if (all_same && v != m_stable[b]) nxt[b] = v;
            end
            case (ET)
                0:       ev = m_stable & ~m_stable_d;
                1:       ev = ~m_stable & m_stable_d;
                default: ev = m_stable ^ m_stable_d;
            endcase
            case (address)
                2'd0:    rdv = m_stable;
                2'd2:    rdv = m_mask;
                2'd3:    rdv = m_edge;
                default: rdv = '0;
            endcase
            clr = '0;
            if (chipselect && !write_n && address == 2'd3) clr = writedata[W-1:0];
            if (chipselect && !write_n && address == 2'd2) m_mask = writedata[W-1:0];
            m_edge = (m_edge & ~clr) | ev;
            m_stable_d = m_stable;
            m_stable = nxt;
            hist.push_front(~in_port);
            void'(hist.pop_back());
            e.rd = {{(32-W){1'b0}}, rdv};
            e.irq = |(m_edge & m_mask);
        end
        sb_q.push_back(e);
    end

    // Monitor: compare DUT outputs with the oldest expectation after each edge
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() == 0) begin
                check("scoreboard_underflow", 32'd0, 32'd1);
            end else begin
                e = sb_q.pop_front();
                check("sb_readdata", readdata, e.rd);
                check("sb_irq", {31'd0, irq}, {31'd0, e.irq});
            end
        end
    end

    initial begin : watchdog
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin : driver
        // 1: reset with all buttons released
        tick(3);
        check("reset_readdata", readdata, 32'h0);
        check("reset_irq", {31'd0, irq}, 32'h0);
        reset_n = 1'b1;
        tick(3);
        check("data_after_reset", readdata, 32'h0);

        // 2: press bit0
        in_port = 4'hE;
        tick(7);
        check("data_press", readdata, 32'h1);
        check("rel_data_press", readdata_r, 32'h1);
        address = 2'd3;
        tick(1);
        check("edge_press", readdata, 32'h1);
        check("rel_edge_press", readdata_r, 32'h0);

        // 3: bit1 glitch of 3 cycles is rejected
        address = 2'd0;
        in_port = 4'hC;
        tick(3);
        in_port = 4'hE;
        tick(8);
        check("data_glitch", readdata, 32'h1);
        address = 2'd3;
        tick(1);
        check("edge_glitch", readdata, 32'h1);

        // 4: mask then W1C
        address = 2'd2; chipselect = 1'b1; write_n = 1'b0; writedata = 32'h1;
        tick(1);
        check("irq_masked_on", {31'd0, irq}, 32'h1);
        address = 2'd3;
        tick(1);
        check("irq_after_w1c", {31'd0, irq}, 32'h0);
        chipselect = 1'b0; write_n = 1'b1;
        tick(2);
        check("edge_after_w1c", readdata, 32'h0);

        // 5: release, then clear bit0 in the same cycle a new press event lands
        in_port = 4'hF;
        tick(8);
        in_port = 4'hE;
        tick(6);
        chipselect = 1'b1; write_n = 1'b0; writedata = 32'h1;
        tick(1);
        chipselect = 1'b0; write_n = 1'b1;
        tick(1);
        check("edge_beats_clear", readdata, 32'h1);
        check("irq_edge_beats_clear", {31'd0, irq}, 32'h1);

        // 6: release bit0; press-type capture unchanged, release-type captures
        address = 2'd0;
        in_port = 4'hF;
        tick(7);
        check("data_release", readdata, 32'h0);
        address = 2'd3;
        tick(1);
        check("edge_release", readdata, 32'h1);
        check("rel_edge_release", readdata_r, 32'h1);
        check("rel_irq_release", {31'd0, irq_r}, 32'h1);

        // Reset mid-debounce with bit2 held through release
        chipselect = 1'b1; write_n = 1'b0; writedata = 32'hF;
        tick(1);
        chipselect = 1'b0; write_n = 1'b1;
        in_port = 4'hB;
        tick(3);
        reset_n = 1'b0;
        tick(1);
        reset_n = 1'b1;
        tick(8);
        check("edge_held_at_reset", readdata, 32'h4);
        address = 2'd0;
        tick(1);
        check("data_held_at_reset", readdata, 32'h4);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int b = 0; b < W; b++) begin
                if ($urandom_range(0, 11) == 0) in_port[b] = ~in_port[b];
            end
            address    = 2'($urandom_range(0, 3));
            chipselect = 1'($urandom_range(0, 1));
            write_n    = ($urandom_range(0, 3) != 0);
            writedata  = $urandom;
            reset_n    = ($urandom_range(0, 599) != 0);
        end
        reset_n = 1'b1;
        tick(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
